// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480@60 VGA timing constants and counter width
package vga_pkg;

    localparam int CNT_W = 10;
    localparam int MAX_TOTAL = 1 << CNT_W;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Sync windows are half-open: [START, END)
    localparam int DEF_HS_START = DEF_H_VISIBLE + DEF_H_FP;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_VISIBLE + DEF_V_FP;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

endpackage

// File: rtl/clk_en_div.sv
// rtl/clk_en_div.sv - divides clk into a registered one-cycle enable every CLK_DIV cycles
module clk_en_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic en_out
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    // en_out rises on the CLK_DIV-th edge after reset; CLK_DIV=1 keeps it high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            en_out  <= 1'b0;
        end else begin
            en_out  <= (div_cnt == LAST);
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, sync/video decode with delay line, frame strobe
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int PIPE_DLY  = 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_en,
    output logic [CNT_W-1:0] xCount,
    output logic [CNT_W-1:0] yCount,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             update,
    output logic [7:0]       frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be 0..4");
    end

    localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_UPD   = CNT_W'(V_VISIBLE - 1);
    // One extra bit so window ends equal to 1024 still compare correctly
    localparam logic [CNT_W:0]   H_VIS   = (CNT_W+1)'(H_VISIBLE);
    localparam logic [CNT_W:0]   V_VIS   = (CNT_W+1)'(V_VISIBLE);
    localparam logic [CNT_W:0]   HS_BEG  = (CNT_W+1)'(H_VISIBLE + H_FP);
    localparam logic [CNT_W:0]   HS_END  = (CNT_W+1)'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W:0]   VS_BEG  = (CNT_W+1)'(V_VISIBLE + V_FP);
    localparam logic [CNT_W:0]   VS_END  = (CNT_W+1)'(V_VISIBLE + V_FP + V_SYNC);

    clk_en_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .rst    (rst),
        .en_out (pix_en)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xCount    <= '0;
            yCount    <= '0;
            update    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            update <= 1'b0;
            if (pix_en) begin
                if (xCount == X_LAST) begin
                    xCount <= '0;
                    yCount <= (yCount == Y_LAST) ? '0 : yCount + CNT_W'(1);
                    // Fires as the raster enters vertical blanking
                    if (yCount == Y_UPD) begin
                        update    <= 1'b1;
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end else begin
                    xCount <= xCount + CNT_W'(1);
                end
            end
        end
    end

    logic [CNT_W:0] xw;
    logic [CNT_W:0] yw;
    logic           hs_raw;
    logic           vs_raw;
    logic           vo_raw;
    logic           hs_act;
    logic           vs_act;
    logic           vo_act;

    assign xw     = {1'b0, xCount};
    assign yw     = {1'b0, yCount};
    assign hs_raw = (xw >= HS_BEG) && (xw < HS_END);
    assign vs_raw = (yw >= VS_BEG) && (yw < VS_END);
    assign vo_raw = (xw < H_VIS) && (yw < V_VIS);

    if (PIPE_DLY == 0) begin : g_nodly
        assign hs_act = hs_raw;
        assign vs_act = vs_raw;
        assign vo_act = vo_raw;
    end else begin : g_dly
        logic [PIPE_DLY-1:0] hs_sr;
        logic [PIPE_DLY-1:0] vs_sr;
        logic [PIPE_DLY-1:0] vo_sr;

        // Shifts every clk so the lag is PIPE_DLY clks regardless of CLK_DIV
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hs_sr <= '0;
                vs_sr <= '0;
                vo_sr <= '0;
            end else begin
                hs_sr[0] <= hs_raw;
                vs_sr[0] <= vs_raw;
                vo_sr[0] <= vo_raw;
                for (int i = 1; i < PIPE_DLY; i++) begin
                    hs_sr[i] <= hs_sr[i-1];
                    vs_sr[i] <= vs_sr[i-1];
                    vo_sr[i] <= vo_sr[i-1];
                end
            end
        end

        assign hs_act = hs_sr[PIPE_DLY-1];
        assign vs_act = vs_sr[PIPE_DLY-1];
        assign vo_act = vo_sr[PIPE_DLY-1];
    end

    assign hsync    = HS_POL ? hs_act : ~hs_act;
    assign vsync    = VS_POL ? vs_act : ~vs_act;
    assign video_on = vo_act;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench: default 640x480 instance plus a tiny-raster instance
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       pix_en, hsync, vsync, video_on, update;
    logic [9:0] xcount, ycount;
    logic [7:0] frame_cnt;

    logic       rst_s;
    logic       pix_en_s, hsync_s, vsync_s, video_on_s, update_s;
    logic [9:0] xcount_s, ycount_s;
    logic [7:0] frame_cnt_s;

    int checks = 0;
    int passed = 0;

    vga_timing_gen dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .xCount(xcount), .yCount(ycount),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .update(update),
        .frame_cnt(frame_cnt)
    );

    // Tiny raster: 16 x 12 total, visible 8 x 6, hsync x=10..12, vsync y=8..9, active-high syncs
    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0)
    ) dut_s (
        .clk(clk), .rst(rst_s), .pix_en(pix_en_s), .xCount(xcount_s), .yCount(ycount_s),
        .hsync(hsync_s), .vsync(vsync_s), .video_on(video_on_s), .update(update_s),
        .frame_cnt(frame_cnt_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        rst_s = 1'b1;
        repeat (3) tick();
        checks++;
        if ({pix_en, update, hsync, vsync, video_on} !== 5'b00110)
            $display("FAIL reset_flags: got %b expected 00110", {pix_en, update, hsync, vsync, video_on});
        else passed++;
        checks++;
        if ({xcount, ycount, frame_cnt} !== 28'd0)
            $display("FAIL reset_counts: got x=%0d y=%0d f=%0d expected 0 0 0", xcount, ycount, frame_cnt);
        else passed++;
        checks++;
        if ({pix_en_s, update_s, hsync_s, vsync_s, video_on_s} !== 5'b00001)
            $display("FAIL reset_flags_small: got %b expected 00001", {pix_en_s, update_s, hsync_s, vsync_s, video_on_s});
        else passed++;
        checks++;
        if ({xcount_s, ycount_s, frame_cnt_s} !== 28'd0)
            $display("FAIL reset_counts_small: got x=%0d y=%0d f=%0d expected 0 0 0", xcount_s, ycount_s, frame_cnt_s);
        else passed++;
    endtask

    task automatic test_divider();
        logic [11:0] exp_v [5];
        exp_v[0] = {1'b0, 1'b1, 10'd0};
        exp_v[1] = {1'b1, 1'b1, 10'd0};
        exp_v[2] = {1'b0, 1'b1, 10'd1};
        exp_v[3] = {1'b1, 1'b1, 10'd1};
        exp_v[4] = {1'b0, 1'b1, 10'd2};
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({pix_en, video_on, xcount} !== exp_v[i])
                $display("FAIL divider_edge%0d: got pix_en=%b vo=%b x=%0d expected pix_en=%b vo=%b x=%0d",
                         i + 1, pix_en, video_on, xcount, exp_v[i][11], exp_v[i][10], exp_v[i][9:0]);
            else passed++;
        end
    endtask

    task automatic test_hsync();
        bit found;
        int n;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            if (xcount == 10'd640) found = 1'b1;
        end
        checks++;
        if (!found) $display("FAIL wait_x640: timed out, x=%0d expected 640", xcount);
        else passed++;
        checks++;
        if (video_on !== 1'b1) $display("FAIL vo_at_x640_delayed: got %b expected 1", video_on);
        else passed++;
        tick();
        checks++;
        if (video_on !== 1'b0) $display("FAIL vo_x640: got %b expected 0", video_on);
        else passed++;

        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (xcount == 10'd656) found = 1'b1;
        end
        checks++;
        if (!found) $display("FAIL wait_x656: timed out, x=%0d expected 656", xcount);
        else passed++;
        checks++;
        if (hsync !== 1'b1) $display("FAIL hsync_at_x656_delayed: got %b expected 1", hsync);
        else passed++;
        n = 0;
        tick();
        while (hsync == 1'b0 && n < 400) begin
            n++;
            checks++;
            if (vsync !== 1'b1) $display("FAIL vsync_line0: got %b expected 1 at x=%0d", vsync, xcount);
            else passed++;
            tick();
        end
        checks++;
        if (n != 192) $display("FAIL hsync_low_clks: got %0d expected 192", n);
        else passed++;
    endtask

    task automatic test_line_wrap();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (xcount == 10'd799 && pix_en == 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) $display("FAIL wait_x799: timed out, x=%0d expected 799", xcount);
        else passed++;
        tick();
        checks++;
        if ({xcount, ycount} !== {10'd0, 10'd1})
            $display("FAIL line_wrap: got x=%0d y=%0d expected 0 1", xcount, ycount);
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 800 && !found; i++) begin
            tick();
            if (xcount == 10'd300) found = 1'b1;
        end
        checks++;
        if (!found || ycount !== 10'd1) $display("FAIL wait_x300: got x=%0d y=%0d expected 300 1", xcount, ycount);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({pix_en, update, hsync, vsync, video_on} !== 5'b00110)
            $display("FAIL midreset_flags: got %b expected 00110", {pix_en, update, hsync, vsync, video_on});
        else passed++;
        checks++;
        if ({xcount, ycount, frame_cnt} !== 28'd0)
            $display("FAIL midreset_counts: got x=%0d y=%0d f=%0d expected 0 0 0", xcount, ycount, frame_cnt);
        else passed++;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({pix_en, xcount, ycount} !== {1'b1, 10'd0, 10'd0})
            $display("FAIL midreset_restart1: got pix_en=%b x=%0d y=%0d expected 1 0 0", pix_en, xcount, ycount);
        else passed++;
        tick();
        checks++;
        if ({pix_en, xcount} !== {1'b0, 10'd1})
            $display("FAIL midreset_restart2: got pix_en=%b x=%0d expected 0 1", pix_en, xcount);
        else passed++;
    endtask

    task automatic test_frame();
        int ex, ey, nupd, last_t;
        logic [7:0] efr;
        logic eu, prev_upd, ehs, evs, evo;
        ex = 0; ey = 0; efr = 8'd0; nupd = 0; last_t = -1; prev_upd = 1'b0;
        rst_s = 1'b0;
        for (int t = 1; t <= 450; t++) begin
            tick();
            if (t > 1) begin
                if (ex == 15) begin
                    ex = 0;
                    ey = (ey == 11) ? 0 : ey + 1;
                end else begin
                    ex = ex + 1;
                end
            end
            eu  = (t > 1) && (ex == 0) && (ey == 6);
            if (eu) efr = efr + 8'd1;
            ehs = (ex >= 10) && (ex < 13);
            evs = (ey >= 8) && (ey < 10);
            evo = (ex < 8) && (ey < 6);
            checks++;
            if ({pix_en_s, xcount_s, ycount_s} !== {1'b1, 10'(ex), 10'(ey)})
                $display("FAIL frame_pos t=%0d: got en=%b x=%0d y=%0d expected 1 %0d %0d", t, pix_en_s, xcount_s, ycount_s, ex, ey);
            else passed++;
            checks++;
            if ({update_s, frame_cnt_s} !== {eu, efr})
                $display("FAIL frame_update t=%0d: got upd=%b f=%0d expected %b %0d", t, update_s, frame_cnt_s, eu, efr);
            else passed++;
            checks++;
            if ({hsync_s, vsync_s, video_on_s} !== {ehs, evs, evo})
                $display("FAIL frame_decode t=%0d (%0d,%0d): got %b expected %b", t, ex, ey,
                         {hsync_s, vsync_s, video_on_s}, {ehs, evs, evo});
            else passed++;
            if (update_s === 1'b1) begin
                nupd++;
                checks++;
                if (prev_upd !== 1'b0) $display("FAIL update_back_to_back t=%0d: got 2 consecutive expected 1", t);
                else passed++;
                if (last_t >= 0) begin
                    checks++;
                    if (t - last_t != 192) $display("FAIL update_spacing: got %0d expected 192", t - last_t);
                    else passed++;
                end
                last_t = t;
            end
            prev_upd = update_s;
        end
        checks++;
        if (nupd != 2) $display("FAIL update_count: got %0d expected 2", nupd);
        else passed++;
    endtask

    task automatic test_reset_mid_small();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (xcount_s == 10'd5 && ycount_s == 10'd3) found = 1'b1;
        end
        checks++;
        if (!found) $display("FAIL wait_small_5_3: timed out at x=%0d y=%0d", xcount_s, ycount_s);
        else passed++;
        #2;
        rst_s = 1'b1;
        #1;
        checks++;
        if ({pix_en_s, update_s, hsync_s, vsync_s, video_on_s} !== 5'b00001)
            $display("FAIL small_midreset_flags: got %b expected 00001", {pix_en_s, update_s, hsync_s, vsync_s, video_on_s});
        else passed++;
        checks++;
        if ({xcount_s, ycount_s, frame_cnt_s} !== 28'd0)
            $display("FAIL small_midreset_counts: got x=%0d y=%0d f=%0d expected 0 0 0", xcount_s, ycount_s, frame_cnt_s);
        else passed++;
        tick();
        rst_s = 1'b0;
        tick();
        checks++;
        if ({pix_en_s, update_s, xcount_s, frame_cnt_s} !== {1'b1, 1'b0, 10'd0, 8'd0})
            $display("FAIL small_restart1: got en=%b upd=%b x=%0d f=%0d expected 1 0 0 0", pix_en_s, update_s, xcount_s, frame_cnt_s);
        else passed++;
        tick();
        checks++;
        if ({update_s, xcount_s, ycount_s} !== {1'b0, 10'd1, 10'd0})
            $display("FAIL small_restart2: got upd=%b x=%0d y=%0d expected 0 1 0", update_s, xcount_s, ycount_s);
        else passed++;
    endtask

    initial begin
        rst   = 1'b1;
        rst_s = 1'b1;
        test_reset();
        test_divider();
        test_hsync();
        test_line_wrap();
        test_reset_mid();
        test_frame();
        test_reset_mid_small();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
